// File: rtl/time_display_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment time display:
// segment codes (active-low {g,f,e,d,c,b,a}), digit index type and anode helpers.
package time_display_scan_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Slot 0 = right field ones ... slot 3 = left field tens.
    typedef logic [1:0] digit_idx_t;

    // One binary time field split into display digits.
    typedef struct packed {
        logic       dash;
        logic [3:0] tens;
        logic [3:0] ones;
    } field_digits_t;

    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/time_display_scan_seg7_encoder.sv
// Combinational BCD digit to active-low 7-segment code; a dash request
// overrides the digit, and non-decimal codes render as an unlit digit.
module seg7_encoder
    import time_display_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (dash_i) begin
            seg_o = SEG_DASH;
        end else begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/time_display_scan.sv
// Four-digit common-anode scan driver for two 0-59 time fields, with
// per-field blinking, decimal points and frame-consistent value snapshots.
module time_display_scan
    import time_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] hi_val,
    input  logic [5:0] lo_val,
    input  logic       blink_hi,
    input  logic       blink_lo,
    input  logic [3:0] dp_mask,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Tens by descending compare chain; anything past 59 is shown as dashes.
    function automatic field_digits_t split_field(input logic [5:0] v);
        field_digits_t r;
        logic [5:0]    tens6;
        logic [5:0]    ones6;
        r = '0;
        if (v >= 6'd60) begin
            r.dash = 1'b1;
        end else begin
            if      (v >= 6'd50) tens6 = 6'd5;
            else if (v >= 6'd40) tens6 = 6'd4;
            else if (v >= 6'd30) tens6 = 6'd3;
            else if (v >= 6'd20) tens6 = 6'd2;
            else if (v >= 6'd10) tens6 = 6'd1;
            else                 tens6 = 6'd0;
            ones6  = v - ((tens6 << 3) + (tens6 << 1));
            r.tens = 4'(tens6);
            r.ones = 4'(ones6);
        end
        return r;
    endfunction

    logic [RW-1:0] ref_q, ref_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    digit_idx_t    idx_q, idx_d;
    logic          started_q, started_d;
    logic [5:0]    hi_snap_q, hi_snap_d;
    logic [5:0]    lo_snap_q, lo_snap_d;
    logic          upd_q, upd_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tc;
    field_digits_t hi_dig, lo_dig;
    logic [3:0]    cur_bcd;
    logic          cur_dash;
    logic [6:0]    enc_seg;
    logic          blank_slot;

    always_comb begin
        tc    = (ref_q == REF_LAST);
        ref_d = tc ? '0 : ref_q + 1'b1;
        upd_d = tc;
    end

    // Blink timebase free-runs regardless of which fields are blinking.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // First terminal count primes the snapshot without stepping past slot 0.
    always_comb begin
        idx_d     = idx_q;
        started_d = started_q;
        hi_snap_d = hi_snap_q;
        lo_snap_d = lo_snap_q;
        if (tc) begin
            if (!started_q) begin
                started_d = 1'b1;
                hi_snap_d = hi_val;
                lo_snap_d = lo_val;
            end else begin
                idx_d = idx_q + 1'b1;
                if (idx_q == 2'd3) begin
                    hi_snap_d = hi_val;
                    lo_snap_d = lo_val;
                end
            end
        end
    end

    always_comb begin
        hi_dig   = split_field(hi_snap_q);
        lo_dig   = split_field(lo_snap_q);
        cur_bcd  = lo_dig.ones;
        cur_dash = lo_dig.dash;
        case (idx_q)
            2'd0: begin cur_bcd = lo_dig.ones; cur_dash = lo_dig.dash; end
            2'd1: begin cur_bcd = lo_dig.tens; cur_dash = lo_dig.dash; end
            2'd2: begin cur_bcd = hi_dig.ones; cur_dash = hi_dig.dash; end
            default: begin cur_bcd = hi_dig.tens; cur_dash = hi_dig.dash; end
        endcase
    end

    seg7_encoder u_seg7_encoder (
        .bcd_i  (cur_bcd),
        .dash_i (cur_dash),
        .seg_o  (enc_seg)
    );

    // Outputs load only on the cycle after a terminal count so anode and seg
    // always change together; disable blanks at once and holds until then.
    always_comb begin
        blank_slot = phase_q & ((blink_hi & idx_q[1]) | (blink_lo & ~idx_q[1]));
        anode_d    = anode_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        if (!en) begin
            anode_d = ANODE_OFF;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
        end else if (upd_q) begin
            if (blank_slot) begin
                anode_d = ANODE_OFF;
                seg_d   = SEG_OFF;
                dp_d    = 1'b1;
            end else begin
                anode_d = anode_for(idx_q);
                seg_d   = enc_seg;
                dp_d    = ~dp_mask[idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            idx_q       <= '0;
            started_q   <= 1'b0;
            hi_snap_q   <= '0;
            lo_snap_q   <= '0;
            upd_q       <= 1'b0;
            anode_q     <= ANODE_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            ref_q       <= ref_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            started_q   <= started_d;
            hi_snap_q   <= hi_snap_d;
            lo_snap_q   <= lo_snap_d;
            upd_q       <= upd_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with REFRESH_DIV=4, BLINK_DIV=32;
// expected slot contents are hand-derived per clock edge after reset release.
module tb_time_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [5:0] hi_val;
    logic [5:0] lo_val;
    logic       blink_hi;
    logic       blink_lo;
    logic [3:0] dp_mask;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    always #5 clk = ~clk;

    time_display_scan #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .hi_val   (hi_val),
        .lo_val   (lo_val),
        .blink_hi (blink_hi),
        .blink_lo (blink_lo),
        .dp_mask  (dp_mask),
        .anode    (anode),
        .seg      (seg),
        .dp       (dp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    // Advance to posedge number 'target' after reset release, sampling 1 unit later.
    task automatic tick_to(input int target);
        while (k < target) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic slot(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic d);
        chk({tag, ".anode"}, 32'(anode), 32'(an));
        chk({tag, ".seg"},   32'(seg),   32'(sg));
        chk({tag, ".dp"},    32'(dp),    32'(d));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at edge %0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        en       = 1'b1;
        hi_val   = 6'd12;
        lo_val   = 6'd34;
        blink_hi = 1'b0;
        blink_lo = 1'b0;
        dp_mask  = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        slot("reset", 4'b1111, 7'b1111111, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        tick_to(4);
        chk("prestart.anode", 32'(anode), 32'(4'b1111));

        // Frame 0: 12:34
        tick_to(5);  slot("f0s0", 4'b1110, 7'b0011001, 1'b1);
        tick_to(9);  slot("f0s1", 4'b1101, 7'b0110000, 1'b1);
        tick_to(13); slot("f0s2", 4'b1011, 7'b0100100, 1'b1);
        lo_val = 6'd59;
        tick_to(17); slot("f0s3", 4'b0111, 7'b1111001, 1'b1);

        // Frame 1 picks up lo=59
        tick_to(21); slot("f1s0", 4'b1110, 7'b0010000, 1'b1);
        tick_to(25); slot("f1s1", 4'b1101, 7'b0010010, 1'b1);
        tick_to(29); slot("f1s2", 4'b1011, 7'b0100100, 1'b1);
        blink_lo = 1'b1;

        // Blink phase 1 covers updates at edges 33..61
        tick_to(33); slot("bl_s3", 4'b0111, 7'b1111001, 1'b1);
        tick_to(37); chk("bl_s0.anode", 32'(anode), 32'(4'b1111));
        tick_to(41); chk("bl_s1.anode", 32'(anode), 32'(4'b1111));
        tick_to(45); slot("bl_s2", 4'b1011, 7'b0100100, 1'b1);
        tick_to(53); chk("bl_s0b.anode", 32'(anode), 32'(4'b1111));
        tick_to(61); slot("bl_s2b", 4'b1011, 7'b0100100, 1'b1);

        // Phase back to 0: all digits visible again
        tick_to(65); slot("vis_s3", 4'b0111, 7'b1111001, 1'b1);
        tick_to(69); slot("vis_s0", 4'b1110, 7'b0010000, 1'b1);
        tick_to(73); slot("vis_s1", 4'b1101, 7'b0010010, 1'b1);
        blink_lo = 1'b0;
        hi_val   = 6'd63;
        dp_mask  = 4'b0100;

        // dp follows mask immediately; hi=63 appears from the next frame
        tick_to(77); slot("dp_s2", 4'b1011, 7'b0100100, 1'b0);
        tick_to(81); slot("dp_s3", 4'b0111, 7'b1111001, 1'b1);
        tick_to(85); slot("dash_s0", 4'b1110, 7'b0010000, 1'b1);
        tick_to(89); slot("dash_s1", 4'b1101, 7'b0010010, 1'b1);
        tick_to(93); slot("dash_s2", 4'b1011, 7'b0111111, 1'b0);
        tick_to(97); slot("dash_s3", 4'b0111, 7'b0111111, 1'b1);

        // Disable mid-slot, re-enable, resume at the next slot boundary
        tick_to(99);
        en = 1'b0;
        tick_to(100); slot("en_off", 4'b1111, 7'b1111111, 1'b1);
        tick_to(102);
        en = 1'b1;
        tick_to(104); slot("en_hold", 4'b1111, 7'b1111111, 1'b1);
        tick_to(105); slot("en_resume", 4'b1101, 7'b0010010, 1'b1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        slot("async_rst", 4'b1111, 7'b1111111, 1'b1);
        #3;
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
